// File: rtl/icache_fill_responder.sv
// Memory-side responder for instruction-cache line fills: reads one aligned line from a
// synchronous SRAM and streams it back as in-order 32-bit beats through a 2-entry buffer.
module icache_fill_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WORDS  = 8,
  parameter int WAIT_CYCLES = 2,
  localparam int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  abort,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rd_data,
  output logic                  fill_valid,
  input  logic                  fill_ready,
  output logic [31:0]           fill_data,
  output logic [IDX_W-1:0]      fill_word_idx,
  output logic                  fill_last,
  output logic                  busy
);

  localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(4 * LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      out_idx;
  logic [WCW-1:0]        wait_cnt;
  logic                  in_flight;
  logic [31:0]           fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [2:0]            committed;
  logic                  credit_ok;

  assign req_ready = (state == S_IDLE) && !abort;
  assign accept    = req_valid && req_ready;

  assign fill_valid    = (fifo_count != 2'd0);
  assign fill_data     = fifo_mem[rd_ptr];
  assign fill_word_idx = out_idx;
  assign fill_last     = fill_valid && (out_idx == LAST_IDX);
  assign busy          = (state != S_IDLE) || fill_valid;

  assign pop  = fill_valid && fill_ready;
  assign push = in_flight && !abort;

  // A new read may only be issued if its data is guaranteed a FIFO slot on arrival.
  assign committed = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
  assign credit_ok = (committed < 3'd2);

  assign mem_rd_en = (state == S_READ) && !abort && credit_ok;
  assign mem_addr  = line_base + ADDR_WIDTH'({rd_idx, 2'b00});

  // Fill sequencing: request capture, wait countdown, read issue and drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      line_base <= '0;
      rd_idx    <= '0;
      wait_cnt  <= '0;
    end else if (abort) begin
      state    <= S_IDLE;
      rd_idx   <= IDX_W'(0);
      wait_cnt <= WCW'(0);
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            line_base <= req_addr & LINE_MASK;
            rd_idx    <= IDX_W'(0);
            wait_cnt  <= WAIT_LOAD;
            state     <= (WAIT_CYCLES == 0) ? S_READ : S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == WCW'(0)) begin
            state <= S_READ;
          end else begin
            wait_cnt <= wait_cnt - WCW'(1);
          end
        end
        S_READ: begin
          if (mem_rd_en) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx <= IDX_W'(0);
              state  <= S_DRAIN;
            end else begin
              rd_idx <= rd_idx + IDX_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (pop && fill_last) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Response buffer; abort drops both buffered beats and the read still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem[0] <= 32'h0;
      fifo_mem[1] <= 32'h0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      in_flight   <= 1'b0;
      out_idx     <= '0;
    end else if (abort) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      in_flight  <= 1'b0;
      out_idx    <= IDX_W'(0);
    end else begin
      in_flight <= mem_rd_en;
      if (push) begin
        fifo_mem[wr_ptr] <= mem_rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        out_idx <= out_idx + IDX_W'(1);
      end
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_icache_fill_responder.sv
// Directed bench for icache_fill_responder: a cycle table for the basic fill plus
// hand-written sequences for back-pressure, abort, zero-wait build and mid-fill reset.
module tb_icache_fill_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        abort = 1'b0;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data = 32'h0;
  logic        fill_valid;
  logic        fill_ready = 1'b0;
  logic [31:0] fill_data;
  logic [2:0]  fill_word_idx;
  logic        fill_last;
  logic        busy;

  logic        z_req_valid = 1'b0;
  logic        z_req_ready;
  logic [31:0] z_req_addr = 32'h0;
  logic        z_abort = 1'b0;
  logic        z_mem_rd_en;
  logic [31:0] z_mem_addr;
  logic [31:0] z_mem_rd_data = 32'h0;
  logic        z_fill_valid;
  logic        z_fill_ready = 1'b0;
  logic [31:0] z_fill_data;
  logic [2:0]  z_fill_word_idx;
  logic        z_fill_last;
  logic        z_busy;

  int checks = 0;
  int errors = 0;

  icache_fill_responder #(.ADDR_WIDTH(32), .LINE_WORDS(8), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .abort(abort), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data),
    .fill_word_idx(fill_word_idx), .fill_last(fill_last), .busy(busy)
  );

  icache_fill_responder #(.ADDR_WIDTH(32), .LINE_WORDS(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_addr(z_req_addr),
    .abort(z_abort), .mem_rd_en(z_mem_rd_en), .mem_addr(z_mem_addr), .mem_rd_data(z_mem_rd_data),
    .fill_valid(z_fill_valid), .fill_ready(z_fill_ready), .fill_data(z_fill_data),
    .fill_word_idx(z_fill_word_idx), .fill_last(z_fill_last), .busy(z_busy)
  );

  // SRAM models: every word holds its own byte address, returned one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_addr;
    if (z_mem_rd_en) z_mem_rd_data <= z_mem_addr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic        fr;
    logic        e_rdy;
    logic        e_busy;
    logic        e_rd;
    logic [31:0] e_maddr;
    logic        e_fv;
    logic [31:0] e_data;
    logic [2:0]  e_idx;
    logic        e_last;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " req_ready"}, req_ready, 32'd1);
    check({tag, " mem_rd_en"}, mem_rd_en, 32'd0);
    check({tag, " mem_addr"}, mem_addr, 32'd0);
    check({tag, " fill_valid"}, fill_valid, 32'd0);
    check({tag, " fill_data"}, fill_data, 32'd0);
    check({tag, " fill_word_idx"}, fill_word_idx, 32'd0);
    check({tag, " fill_last"}, fill_last, 32'd0);
    check({tag, " busy"}, busy, 32'd0);
  endtask

  // mode 0: fill_ready toggles every cycle; mode 1: fill_ready low for 20 cycles, then high.
  task automatic run_line(input logic [31:0] addr, input int mode);
    logic [31:0] base;
    int beats;
    int reads;
    int stall_reads;
    int max_out;
    int cyc;
    base = addr & 32'hFFFF_FFE0;
    beats = 0;
    reads = 0;
    stall_reads = 0;
    max_out = 0;
    cyc = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr = addr;
    fill_ready = 1'b0;
    @(negedge clk);
    check("line req_ready idle", req_ready, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (beats < 8 && cyc < 200) begin
      fill_ready = (mode == 0) ? cyc[0] : (cyc >= 20);
      @(negedge clk);
      if (mem_rd_en) begin
        reads++;
        if (cyc < 20) stall_reads++;
      end
      if (fill_valid && fill_ready) begin
        check("line beat data", fill_data, base + 32'(4 * beats));
        check("line beat idx", fill_word_idx, 32'(beats));
        check("line beat last", fill_last, 32'(beats == 7));
        beats++;
      end
      if (reads - beats > max_out) max_out = reads - beats;
      @(posedge clk); #1;
      cyc++;
    end
    check("line beat count", beats, 32'd8);
    check("line read count", reads, 32'd8);
    check("line outstanding<=2", 32'(max_out <= 2), 32'd1);
    if (mode == 1) check("stall reads", stall_reads, 32'd2);
    fill_ready = 1'b0;
    @(negedge clk);
    check("line end busy", busy, 32'd0);
    check("line end req_ready", req_ready, 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 14; k++) begin
      vecs[k].rv      = (k == 0);
      vecs[k].ra      = (k == 0) ? 32'h44 : 32'h0;
      vecs[k].fr      = 1'b1;
      vecs[k].e_rdy   = (k == 0) || (k == 13);
      vecs[k].e_busy  = (k >= 1) && (k <= 12);
      vecs[k].e_rd    = (k >= 3) && (k <= 10);
      vecs[k].e_maddr = 32'h40 + 32'(4 * (k - 3));
      vecs[k].e_fv    = (k >= 5) && (k <= 12);
      vecs[k].e_data  = 32'h40 + 32'(4 * (k - 5));
      vecs[k].e_idx   = 3'(k - 5);
      vecs[k].e_last  = (k == 12);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    check("z reset busy", z_busy, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Basic fill of the line holding 0x44, one row per cycle.
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      req_valid  = vecs[k].rv;
      req_addr   = vecs[k].ra;
      fill_ready = vecs[k].fr;
      @(negedge clk);
      check($sformatf("row%0d req_ready", k), req_ready, 32'(vecs[k].e_rdy));
      check($sformatf("row%0d busy", k), busy, 32'(vecs[k].e_busy));
      check($sformatf("row%0d mem_rd_en", k), mem_rd_en, 32'(vecs[k].e_rd));
      check($sformatf("row%0d fill_valid", k), fill_valid, 32'(vecs[k].e_fv));
      check($sformatf("row%0d fill_last", k), fill_last, 32'(vecs[k].e_last));
      if (vecs[k].e_rd) check($sformatf("row%0d mem_addr", k), mem_addr, vecs[k].e_maddr);
      if (vecs[k].e_fv) begin
        check($sformatf("row%0d fill_data", k), fill_data, vecs[k].e_data);
        check($sformatf("row%0d fill_word_idx", k), fill_word_idx, 32'(vecs[k].e_idx));
      end
    end
    @(posedge clk); #1;
    fill_ready = 1'b0;

    run_line(32'h44, 0);
    run_line(32'h44, 1);

    // Abort on the third beat of line 0x20.
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr = 32'h20;
    fill_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(negedge clk);
    check("abort beat2 valid", fill_valid, 32'd1);
    check("abort beat2 data", fill_data, 32'h28);
    check("abort beat2 idx", fill_word_idx, 32'd2);
    check("abort cycle no read", mem_rd_en, 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    fill_ready = 1'b0;
    @(negedge clk);
    check("after abort fill_valid", fill_valid, 32'd0);
    check("after abort req_ready", req_ready, 32'd1);
    check("after abort busy", busy, 32'd0);
    check("after abort mem_rd_en", mem_rd_en, 32'd0);

    // Abort in IDLE blocks a simultaneous request.
    @(posedge clk); #1;
    abort = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h80;
    @(posedge clk); #1;
    abort = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("idle abort not accepted", busy, 32'd0);

    run_line(32'h00, 0);

    // Zero-wait build: read right after accept, first beat two cycles after accept.
    @(posedge clk); #1;
    z_req_valid = 1'b1;
    z_req_addr = 32'h0;
    z_fill_ready = 1'b1;
    @(negedge clk);
    check("z req_ready", z_req_ready, 32'd1);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      z_req_valid = 1'b0;
      @(negedge clk);
      check($sformatf("z row%0d mem_rd_en", k), z_mem_rd_en, 32'((k >= 1) && (k <= 8)));
      check($sformatf("z row%0d fill_valid", k), z_fill_valid, 32'((k >= 3) && (k <= 10)));
      check($sformatf("z row%0d busy", k), z_busy, 32'(k <= 10));
      check($sformatf("z row%0d fill_last", k), z_fill_last, 32'(k == 10));
      if (k == 1) check("z first read addr", z_mem_addr, 32'h0);
      if ((k >= 3) && (k <= 10)) begin
        check($sformatf("z row%0d fill_data", k), z_fill_data, 32'(4 * (k - 3)));
        check($sformatf("z row%0d idx", k), z_fill_word_idx, 32'(k - 3));
      end
    end
    z_fill_ready = 1'b0;

    // Reset asserted while reading line 0x40.
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr = 32'h40;
    fill_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("midfill reset");
    @(posedge clk); #1;
    rst = 1'b1;
    fill_ready = 1'b0;

    run_line(32'h00, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
